// File: rtl/steer_quad_encoder.sv
// Left/right steering buttons -> accelerating 2-bit quadrature {A,B} for the sprint2 core.
// Define STEER_DEBOUNCE_EN to insert a synchronizer plus stability filter on the buttons.
module steer_quad_encoder #(
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned START_DIV  = 22500,
    parameter int unsigned MIN_DIV    = 5625,
    parameter int unsigned ACCEL_STEP = 1125,
    parameter int unsigned DEB_CYCLES = 1024
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       left,
    input  logic       right,
    output logic [1:0] steer,
    output logic       dir,
    output logic       moving
);

    // state      | meaning
    // ST_IDLE    | no direction (none or both pressed); phase holds, timer parked
    // ST_RUN_CW  | right held; phase steps +1 whenever the timer expires
    // ST_RUN_CCW | left held; phase steps -1 whenever the timer expires
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN_CW  = 2'd1,
        ST_RUN_CCW = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] START_V  = DIV_W'(START_DIV);
    localparam logic [DIV_W-1:0] START_M1 = DIV_W'(START_DIV - 1);
    localparam logic [DIV_W-1:0] MIN_V    = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] ACCEL_V  = DIV_W'(ACCEL_STEP);

    if (MIN_DIV == 0 || MIN_DIV > START_DIV || DEB_CYCLES == 0) begin : g_bad_params
        $error("steer_quad_encoder: illegal parameter set");
    end

    logic w_r;
    logic w_l;

`ifdef STEER_DEBOUNCE_EN
    localparam int unsigned      DEB_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    // bit 1 = right, bit 0 = left
    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;
    logic [1:0]       r_deb;
    logic [DEB_W-1:0] r_deb_cnt [2];

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_sync1      <= 2'b00;
            r_sync2      <= 2'b00;
            r_deb        <= 2'b00;
            r_deb_cnt[0] <= '0;
            r_deb_cnt[1] <= '0;
        end else begin
            r_sync1 <= {right, left};
            r_sync2 <= r_sync1;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DEB_LAST) begin
                    r_deb[i]     <= r_sync2[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_r = r_deb[1];
    assign w_l = r_deb[0];
`else
    assign w_r = right;
    assign w_l = left;
`endif

    state_t           r_state;
    logic [1:0]       r_phase;
    logic [1:0]       r_steer;
    logic             r_dir;
    logic [DIV_W-1:0] r_period;
    logic [DIV_W-1:0] r_cnt;

    state_t           w_req;
    state_t           w_state_nxt;
    logic [1:0]       w_phase_nxt;
    logic             w_dir_nxt;
    logic [DIV_W-1:0] w_period_nxt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [DIV_W-1:0] w_period_sub;
    logic [DIV_W-1:0] w_period_dec;
    logic [1:0]       w_gray;

    // Saturating acceleration; the ACCEL_V guard keeps the subtraction from wrapping.
    assign w_period_sub = r_period - ACCEL_V;
    assign w_period_dec = (r_period <= ACCEL_V || w_period_sub < MIN_V) ? MIN_V : w_period_sub;
    assign w_gray       = {r_phase[1], r_phase[1] ^ r_phase[0]};

    always_comb begin
        w_req        = ST_IDLE;
        w_state_nxt  = r_state;
        w_phase_nxt  = r_phase;
        w_dir_nxt    = r_dir;
        w_period_nxt = r_period;
        w_cnt_nxt    = r_cnt;

        if (w_r && !w_l) begin
            w_req = ST_RUN_CW;
        end else if (w_l && !w_r) begin
            w_req = ST_RUN_CCW;
        end

        if (w_req == ST_IDLE) begin
            w_state_nxt  = ST_IDLE;
            w_period_nxt = START_V;
            w_cnt_nxt    = START_M1;
        end else if (w_req != r_state) begin
            w_state_nxt  = w_req;
            w_period_nxt = START_V;
            w_cnt_nxt    = START_M1;
            w_dir_nxt    = (w_req == ST_RUN_CW);
        end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - 1'b1;
        end else begin
            w_phase_nxt  = (r_state == ST_RUN_CW) ? r_phase + 2'd1 : r_phase - 2'd1;
            w_period_nxt = w_period_dec;
            w_cnt_nxt    = w_period_dec - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_phase  <= 2'd0;
            r_steer  <= 2'b00;
            r_dir    <= 1'b0;
            r_period <= START_V;
            r_cnt    <= START_M1;
        end else begin
            r_state  <= w_state_nxt;
            r_phase  <= w_phase_nxt;
            r_steer  <= w_gray;
            r_dir    <= w_dir_nxt;
            r_period <= w_period_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign steer  = r_steer;
    assign dir    = r_dir;
    assign moving = (r_state != ST_IDLE);

endmodule

// File: tb/tb_steer_quad_encoder.sv
// Bench for steer_quad_encoder: directed spec scenarios plus random button traffic vs a timestamp model.
module tb_steer_quad_encoder;
    localparam int START = 8;
    localparam int MIN   = 2;
    localparam int ACC   = 2;
    localparam int DEB   = 4;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       left = 1'b0;
    logic       right = 1'b0;
    logic [1:0] steer;
    logic       dir;
    logic       moving;

    always #5 CLK = ~CLK;

    steer_quad_encoder #(
        .DIV_W(16), .START_DIV(START), .MIN_DIV(MIN), .ACCEL_STEP(ACC), .DEB_CYCLES(DEB)
    ) dut (
        .CLK(CLK), .reset(reset), .left(left), .right(right),
        .steer(steer), .dir(dir), .moving(moving)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Model: direction, absolute due time of the next step, current period, phase.
    int         m_state = 0;   // 0 idle, +1 CW, -1 CCW
    int         m_period = START;
    int         m_due = 0;
    int         m_phase = 0;
    logic [1:0] m_steer = 2'b00;
    logic       m_dir = 1'b0;
    logic [1:0] gray_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    task automatic clk_edge();
        int want;
        @(posedge CLK);
        cyc++;
        if (reset) begin
            m_state = 0; m_phase = 0; m_steer = 2'b00; m_dir = 1'b0;
        end else begin
            m_steer = gray_tab[m_phase];
            want = (right && !left) ? 1 : ((left && !right) ? -1 : 0);
            if (want == 0) begin
                m_state = 0;
            end else if (want != m_state) begin
                m_state = want; m_period = START; m_due = cyc + START; m_dir = (want == 1);
            end else if (cyc == m_due) begin
                m_phase  = (m_phase + 4 + want) % 4;
                m_period = (m_period - ACC < MIN) ? MIN : m_period - ACC;
                m_due    = cyc + m_period;
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; left = 1'b0; right = 1'b0;
        clk_edge();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int k = 0; k < 50; k++) begin
            clk_edge();
            n_checks++;
            if (steer !== 2'b00 || moving !== 1'b0 || dir !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_idle k=%0d got steer=%b moving=%b dir=%b exp 00/0/0", k, steer, moving, dir);
            end
        end
    endtask

    task automatic test_cw_accel();
        int steps [5] = '{8, 14, 18, 20, 22};
        int n;
        logic [1:0] exp;
        apply_reset();
        right = 1'b1;
        clk_edge();
        n_checks++;
        if (moving !== 1'b1 || dir !== 1'b1) begin
            n_errors++;
            $display("FAIL cw_entry got moving=%b dir=%b exp 1/1", moving, dir);
        end
        for (int k = 1; k <= 24; k++) begin
            clk_edge();
            n = 0;
            foreach (steps[j]) if (steps[j] < k) n++;
            exp = gray_tab[n % 4];
            n_checks++;
            if (steer !== exp || moving !== 1'b1 || dir !== 1'b1) begin
                n_errors++;
                $display("FAIL cw_accel t=%0d got steer=%b mv=%b dir=%b exp steer=%b mv=1 dir=1", k, steer, moving, dir, exp);
            end
        end
    endtask

    task automatic test_ccw_wrap();
        logic [1:0] exp;
        apply_reset();
        left = 1'b1;
        clk_edge();
        for (int k = 1; k <= 16; k++) begin
            clk_edge();
            exp = (k < 9) ? 2'b00 : ((k < 15) ? 2'b10 : 2'b11);
            n_checks++;
            if (steer !== exp || dir !== 1'b0 || moving !== 1'b1) begin
                n_errors++;
                $display("FAIL ccw_wrap t=%0d got steer=%b dir=%b mv=%b exp steer=%b dir=0 mv=1", k, steer, dir, moving, exp);
            end
        end
    endtask

    task automatic test_both_high();
        apply_reset();
        right = 1'b1;
        for (int k = 0; k <= 15; k++) clk_edge();
        left = 1'b1;
        for (int k = 0; k < 5; k++) begin
            clk_edge();
            n_checks++;
            if (steer !== 2'b11 || moving !== 1'b0) begin
                n_errors++;
                $display("FAIL both_high k=%0d got steer=%b mv=%b exp 11/0", k, steer, moving);
            end
        end
        left = 1'b0;
        clk_edge();
        n_checks++;
        if (moving !== 1'b1) begin
            n_errors++;
            $display("FAIL both_reentry got mv=%b exp 1", moving);
        end
        for (int k = 1; k <= 9; k++) begin
            clk_edge();
            n_checks++;
            if (steer !== ((k < 9) ? 2'b11 : 2'b10)) begin
                n_errors++;
                $display("FAIL both_restart t=%0d got steer=%b exp %b", k, steer, (k < 9) ? 2'b11 : 2'b10);
            end
        end
    endtask

    task automatic test_reversal();
        apply_reset();
        right = 1'b1;
        for (int k = 0; k <= 16; k++) clk_edge();
        right = 1'b0; left = 1'b1;
        clk_edge();
        n_checks++;
        if (dir !== 1'b0 || moving !== 1'b1 || steer !== 2'b11) begin
            n_errors++;
            $display("FAIL rev_entry got dir=%b mv=%b steer=%b exp 0/1/11", dir, moving, steer);
        end
        for (int k = 18; k <= 26; k++) begin
            clk_edge();
            n_checks++;
            if (steer !== ((k < 26) ? 2'b11 : 2'b01)) begin
                n_errors++;
                $display("FAIL rev_step t=%0d got steer=%b exp %b", k, steer, (k < 26) ? 2'b11 : 2'b01);
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        right = 1'b1;
        for (int k = 0; k <= 11; k++) clk_edge();
        reset = 1'b1;
        clk_edge();
        n_checks++;
        if (steer !== 2'b00 || moving !== 1'b0 || dir !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset got steer=%b mv=%b dir=%b exp 00/0/0", steer, moving, dir);
        end
        reset = 1'b0;
        clk_edge();
        n_checks++;
        if (moving !== 1'b1 || dir !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_reentry got mv=%b dir=%b exp 1/1", moving, dir);
        end
        for (int k = 1; k <= 9; k++) begin
            clk_edge();
            n_checks++;
            if (steer !== ((k < 9) ? 2'b00 : 2'b01)) begin
                n_errors++;
                $display("FAIL mid_restart t=%0d got steer=%b exp %b", k, steer, (k < 9) ? 2'b00 : 2'b01);
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 19) == 0) {left, right} = 2'($urandom_range(0, 3));
            reset = ($urandom_range(0, 499) == 0);
            clk_edge();
            n_checks++;
            if (steer !== m_steer || dir !== m_dir || moving !== (m_state != 0)) begin
                n_errors++;
                $display("FAIL random k=%0d got steer=%b dir=%b mv=%b exp steer=%b dir=%b mv=%b",
                         k, steer, dir, moving, m_steer, m_dir, m_state != 0);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_debounce();
        int first;
        apply_reset();
        for (int p = 0; p < 3; p++) begin
            right = 1'b1;
            for (int k = 0; k < 3; k++) clk_edge();
            right = 1'b0;
            for (int k = 0; k < 6; k++) begin
                clk_edge();
                n_checks++;
                if (moving !== 1'b0) begin
                    n_errors++;
                    $display("FAIL deb_pulse p=%0d k=%0d got mv=%b exp 0", p, k, moving);
                end
            end
        end
        right = 1'b1;
        first = 0;
        for (int k = 1; k <= 40 && first == 0; k++) begin
            clk_edge();
            if (moving === 1'b1) first = k;
        end
        n_checks++;
        if (first != 1 + 2 + DEB) begin
            n_errors++;
            $display("FAIL deb_latency got first_moving_edge=%0d exp %0d", first, 1 + 2 + DEB);
        end
    endtask

    initial begin
        test_reset();
`ifdef STEER_DEBOUNCE_EN
        test_debounce();
`else
        test_cw_accel();
        test_ccw_wrap();
        test_both_high();
        test_reversal();
        test_reset_mid();
        test_random();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
